// File: rtl/skolem_sweep_checker_if.sv
// Bus between the sweep checker and the Skolem-function block under test.
// The checker (master) drives the s/t operands; the Skolem block (slave)
// returns the combinational witness x.
interface skolem_sweep_checker_if #(
    parameter int W = 4
);
    logic [W-1:0] sk_s;
    logic [W-1:0] sk_t;
    logic [W-1:0] sk_x;

    modport master (output sk_s, output sk_t, input sk_x);
    modport slave  (input sk_s, input sk_t, output sk_x);
endinterface

// File: rtl/skolem_sweep_checker.sv
// Sweeps every (s,t) pair into a Skolem block, brute-forces whether a witness
// x with (x >>u s) <s t exists, and counts pairs where the returned witness
// is wrong.
// Optional macro FAIL_STOP_EN: stop the sweep at the first failing pair.
module skolem_sweep_checker #(
    parameter int W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    skolem_sweep_checker_if.master sk,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*W:0]         fail_count,
    output logic [2*W:0]         unsat_count,
    output logic                 first_fail_valid,
    output logic [W-1:0]         first_fail_s,
    output logic [W-1:0]         first_fail_t
);

    localparam int CW = 2 * W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SEARCH,
        S_CHECK,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [2*W-1:0]  r_p;
    logic [W-1:0]    r_cand;
    logic [W-1:0]    r_x;
    logic            r_exists;
    logic [CW-1:0]   r_fail_cnt;
    logic [CW-1:0]   r_unsat_cnt;
    logic            r_ffv;
    logic [W-1:0]    r_ffs;
    logic [W-1:0]    r_fft;
    logic            r_pass;
    logic            r_armed;

    logic [W-1:0]    w_s;
    logic [W-1:0]    w_t;
    logic            w_cand_ok;
    logic            w_new_fail;
    logic            w_last;
    logic            w_accept;
    logic [CW-1:0]   w_fail_nxt;

    // Invertibility condition: logical right shift (0 for s >= W), then
    // signed less-than against t.
    function automatic logic cond(input logic [W-1:0] x,
                                  input logic [W-1:0] s,
                                  input logic [W-1:0] t);
        logic [W-1:0] sh;
        sh = (int'(s) >= W) ? '0 : (x >> s);
        return $signed(sh) < $signed(t);
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == '1) ? c : (c + CW'(1));
    endfunction

    assign w_s        = r_p[W-1:0];
    assign w_t        = r_p[2*W-1:W];
    assign w_cand_ok  = cond(r_cand, w_s, w_t);
    assign w_new_fail = r_exists && !w_cand_ok;
    assign w_last     = (r_p == '1);
    assign w_accept   = start && r_armed;
    assign w_fail_nxt = w_new_fail ? sat_inc(r_fail_cnt) : r_fail_cnt;

    assign sk.sk_s          = w_s;
    assign sk.sk_t          = w_t;
    assign busy             = (r_state == S_APPLY) || (r_state == S_SEARCH) ||
                              (r_state == S_CHECK);
    assign done             = (r_state == S_DONE);
    assign pass             = r_pass;
    assign fail_count       = r_fail_cnt;
    assign unsat_count      = r_unsat_cnt;
    assign first_fail_valid = r_ffv;
    assign first_fail_s     = r_ffs;
    assign first_fail_t     = r_fft;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic for the sweep sequencer.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_accept) w_next = S_APPLY;
            S_APPLY:  w_next = S_SEARCH;
            S_SEARCH: if (r_x == '1) w_next = S_CHECK;
            S_CHECK: begin
`ifdef FAIL_STOP_EN
                if (w_new_fail || w_last) w_next = S_DONE;
                else                      w_next = S_APPLY;
`else
                if (w_last) w_next = S_DONE;
                else        w_next = S_APPLY;
`endif
            end
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Sweep datapath: pair index, candidate capture, search, and result counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p         <= '0;
            r_cand      <= '0;
            r_x         <= '0;
            r_exists    <= 1'b0;
            r_fail_cnt  <= '0;
            r_unsat_cnt <= '0;
            r_ffv       <= 1'b0;
            r_ffs       <= '0;
            r_fft       <= '0;
            r_pass      <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            // A start coinciding with reset release is not accepted.
            r_armed <= 1'b1;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_p         <= '0;
                        r_fail_cnt  <= '0;
                        r_unsat_cnt <= '0;
                        r_ffv       <= 1'b0;
                        r_ffs       <= '0;
                        r_fft       <= '0;
                        r_pass      <= 1'b0;
                    end
                end
                S_APPLY: begin
                    r_cand   <= sk.sk_x;
                    r_x      <= '0;
                    r_exists <= 1'b0;
                end
                S_SEARCH: begin
                    r_exists <= r_exists | cond(r_x, w_s, w_t);
                    r_x      <= r_x + W'(1);
                end
                S_CHECK: begin
                    if (!r_exists) begin
                        r_unsat_cnt <= sat_inc(r_unsat_cnt);
                    end else if (!w_cand_ok) begin
                        r_fail_cnt <= w_fail_nxt;
                        if (!r_ffv) begin
                            r_ffv <= 1'b1;
                            r_ffs <= w_s;
                            r_fft <= w_t;
                        end
                    end
                    if (w_next == S_DONE) r_pass <= (w_fail_nxt == '0);
                    else                  r_p    <= r_p + (2*W)'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
